// File: rtl/serdesphy_powerup_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : serdesphy_powerup_sequencer
//  Description : Brings the SERDES PHY from off to ready through PLL/CDR reset
//                pulses and lock waits. Handles timeouts, bounded retries and
//                lock-loss recovery.
//  Revision    : 1.0  initial release
// ============================================================================
module serdesphy_powerup_sequencer #(
    parameter int RST_PULSE_CYCLES = 4,
    parameter int PLL_TIMEOUT      = 512,
    parameter int CDR_TIMEOUT      = 2047,
    parameter int MAX_RETRIES      = 3
) (
    input  logic       clk_ref_24m,
    input  logic       rst_n,
    input  logic       seq_en,
    input  logic       pll_lock,
    input  logic       cdr_lock,
    input  logic       phy_ready,
    output logic       phy_en,
    output logic       pll_rst,
    output logic       cdr_rst,
    output logic       seq_busy,
    output logic       seq_ready,
    output logic       seq_fault,
    output logic [1:0] fault_code,
    output logic [3:0] retry_cnt,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PLL_RST  = 3'd1,
        ST_PLL_WAIT = 3'd2,
        ST_CDR_RST  = 3'd3,
        ST_CDR_WAIT = 3'd4,
        ST_READY    = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

    localparam logic [11:0] c_rst_last  = 12'(RST_PULSE_CYCLES - 1);
    localparam logic [11:0] c_pll_last  = 12'(PLL_TIMEOUT - 1);
    localparam logic [11:0] c_cdr_last  = 12'(CDR_TIMEOUT - 1);
    localparam logic [11:0] c_timer_max = 12'hFFF;
    localparam logic [3:0]  c_max_retry = 4'(MAX_RETRIES);

    localparam logic [1:0] c_code_none = 2'b00;
    localparam logic [1:0] c_code_pll  = 2'b01;
    localparam logic [1:0] c_code_cdr  = 2'b10;
    localparam logic [1:0] c_code_lost = 2'b11;

    state_t      r_state;
    state_t      w_next_state;
    state_t      w_esc_target;
    logic [11:0] r_timer;
    logic [3:0]  r_retry_cnt;
    logic [3:0]  w_next_retry;
    logic [1:0]  r_fault_code;
    logic [1:0]  w_next_code;
    logic [1:0]  w_esc_code;
    logic        w_restart;
    logic        w_escalate;
    logic        w_retry_ok;

    logic        r_phy_en;
    logic        r_pll_rst;
    logic        r_cdr_rst;
    logic        r_seq_busy;
    logic        r_seq_ready;
    logic        r_seq_fault;
    logic        w_phy_en;
    logic        w_pll_rst;
    logic        w_cdr_rst;
    logic        w_seq_busy;
    logic        w_seq_ready;
    logic        w_seq_fault;

    assign w_retry_ok = (r_retry_cnt < c_max_retry);

    // Next-state logic; w_escalate marks a timeout or lock-loss that consumes
    // a retry or, once retries are exhausted, lands in FAULT.
    always_comb begin
        w_next_state = r_state;
        w_next_retry = r_retry_cnt;
        w_next_code  = r_fault_code;
        w_restart    = 1'b0;
        w_escalate   = 1'b0;
        w_esc_target = r_state;
        w_esc_code   = c_code_none;

        if (!seq_en) begin
            w_next_state = ST_IDLE;
            w_next_retry = 4'd0;
            w_next_code  = c_code_none;
            w_restart    = (r_state != ST_IDLE);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_PLL_RST;
                    w_restart    = 1'b1;
                end
                ST_PLL_RST: begin
                    if (r_timer == c_rst_last) begin
                        w_next_state = ST_PLL_WAIT;
                        w_restart    = 1'b1;
                    end
                end
                ST_PLL_WAIT: begin
                    if (pll_lock) begin
                        w_next_state = ST_CDR_RST;
                        w_restart    = 1'b1;
                    end else if (r_timer == c_pll_last) begin
                        w_escalate   = 1'b1;
                        w_esc_target = ST_PLL_RST;
                        w_esc_code   = c_code_pll;
                    end
                end
                ST_CDR_RST: begin
                    if (!pll_lock) begin
                        w_escalate   = 1'b1;
                        w_esc_target = ST_PLL_RST;
                        w_esc_code   = c_code_lost;
                    end else if (r_timer == c_rst_last) begin
                        w_next_state = ST_CDR_WAIT;
                        w_restart    = 1'b1;
                    end
                end
                ST_CDR_WAIT: begin
                    // cdr_lock alone is not enough: phy_ready lags it
                    if (phy_ready) begin
                        w_next_state = ST_READY;
                        w_restart    = 1'b1;
                    end else if (!pll_lock) begin
                        w_escalate   = 1'b1;
                        w_esc_target = ST_PLL_RST;
                        w_esc_code   = c_code_lost;
                    end else if (r_timer == c_cdr_last) begin
                        w_escalate   = 1'b1;
                        w_esc_target = ST_CDR_RST;
                        w_esc_code   = c_code_cdr;
                    end
                end
                ST_READY: begin
                    if (!pll_lock) begin
                        w_escalate   = 1'b1;
                        w_esc_target = ST_PLL_RST;
                        w_esc_code   = c_code_lost;
                    end else if (!cdr_lock || !phy_ready) begin
                        w_escalate   = 1'b1;
                        w_esc_target = ST_CDR_RST;
                        w_esc_code   = c_code_lost;
                    end
                end
                ST_FAULT: begin
                    w_next_state = ST_FAULT;
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_restart    = 1'b1;
                end
            endcase

            if (w_escalate) begin
                w_restart = 1'b1;
                if (w_retry_ok) begin
                    w_next_state = w_esc_target;
                    w_next_retry = r_retry_cnt + 4'd1;
                end else begin
                    w_next_state = ST_FAULT;
                    w_next_code  = w_esc_code;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they register with it
    always_comb begin
        w_phy_en    = 1'b0;
        w_pll_rst   = 1'b0;
        w_cdr_rst   = 1'b0;
        w_seq_busy  = 1'b0;
        w_seq_ready = 1'b0;
        w_seq_fault = 1'b0;
        case (w_next_state)
            ST_PLL_RST: begin
                w_phy_en   = 1'b1;
                w_pll_rst  = 1'b1;
                w_cdr_rst  = 1'b1;
                w_seq_busy = 1'b1;
            end
            ST_PLL_WAIT, ST_CDR_RST: begin
                w_phy_en   = 1'b1;
                w_cdr_rst  = 1'b1;
                w_seq_busy = 1'b1;
            end
            ST_CDR_WAIT: begin
                w_phy_en   = 1'b1;
                w_seq_busy = 1'b1;
            end
            ST_READY: begin
                w_phy_en    = 1'b1;
                w_seq_ready = 1'b1;
            end
            ST_FAULT: begin
                w_seq_fault = 1'b1;
            end
            default: begin
                w_phy_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_timer      <= 12'd0;
            r_retry_cnt  <= 4'd0;
            r_fault_code <= c_code_none;
            r_phy_en     <= 1'b0;
            r_pll_rst    <= 1'b0;
            r_cdr_rst    <= 1'b0;
            r_seq_busy   <= 1'b0;
            r_seq_ready  <= 1'b0;
            r_seq_fault  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_retry_cnt  <= w_next_retry;
            r_fault_code <= w_next_code;
            r_phy_en     <= w_phy_en;
            r_pll_rst    <= w_pll_rst;
            r_cdr_rst    <= w_cdr_rst;
            r_seq_busy   <= w_seq_busy;
            r_seq_ready  <= w_seq_ready;
            r_seq_fault  <= w_seq_fault;
            // Saturates in the states that have no timeout of their own
            if (w_restart) begin
                r_timer <= 12'd0;
            end else if (r_timer != c_timer_max) begin
                r_timer <= r_timer + 12'd1;
            end
        end
    end

    assign phy_en     = r_phy_en;
    assign pll_rst    = r_pll_rst;
    assign cdr_rst    = r_cdr_rst;
    assign seq_busy   = r_seq_busy;
    assign seq_ready  = r_seq_ready;
    assign seq_fault  = r_seq_fault;
    assign fault_code = r_fault_code;
    assign retry_cnt  = r_retry_cnt;
    assign seq_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_serdesphy_powerup_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_serdesphy_powerup_sequencer
//  Description : Self-checking bench; expected state transitions are queued as
//                stimulus is applied and compared as the sequencer moves.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serdesphy_powerup_sequencer;

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_pll_rst  = 3'd1;
    localparam logic [2:0] c_pll_wait = 3'd2;
    localparam logic [2:0] c_cdr_rst  = 3'd3;
    localparam logic [2:0] c_cdr_wait = 3'd4;
    localparam logic [2:0] c_ready    = 3'd5;
    localparam logic [2:0] c_fault    = 3'd6;

    logic       clk_ref_24m = 1'b0;
    logic       rst_n       = 1'b1;
    logic       seq_en      = 1'b0;
    logic       pll_lock    = 1'b0;
    logic       cdr_lock    = 1'b0;
    logic       phy_ready   = 1'b0;
    logic       phy_en;
    logic       pll_rst;
    logic       cdr_rst;
    logic       seq_busy;
    logic       seq_ready;
    logic       seq_fault;
    logic [1:0] fault_code;
    logic [3:0] retry_cnt;
    logic [2:0] seq_state;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          t0;
    logic        mon_en   = 1'b0;
    logic [2:0]  prev_state = 3'd0;
    logic [14:0] sb_q[$];

    serdesphy_powerup_sequencer #(
        .RST_PULSE_CYCLES (4),
        .PLL_TIMEOUT      (512),
        .CDR_TIMEOUT      (2047),
        .MAX_RETRIES      (3)
    ) u_dut (
        .clk_ref_24m (clk_ref_24m),
        .rst_n       (rst_n),
        .seq_en      (seq_en),
        .pll_lock    (pll_lock),
        .cdr_lock    (cdr_lock),
        .phy_ready   (phy_ready),
        .phy_en      (phy_en),
        .pll_rst     (pll_rst),
        .cdr_rst     (cdr_rst),
        .seq_busy    (seq_busy),
        .seq_ready   (seq_ready),
        .seq_fault   (seq_fault),
        .fault_code  (fault_code),
        .retry_cnt   (retry_cnt),
        .seq_state   (seq_state)
    );

    always #20 clk_ref_24m = ~clk_ref_24m;

    always @(posedge clk_ref_24m) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {state, phy_en, pll_rst, cdr_rst, busy, ready, fault, retry_cnt, fault_code}
    function automatic logic [14:0] exp_vec(input logic [2:0] st, input logic [3:0] rc,
                                            input logic [1:0] fc);
        logic [5:0] o;
        case (st)
            c_pll_rst:  o = 6'b111_100;
            c_pll_wait: o = 6'b101_100;
            c_cdr_rst:  o = 6'b101_100;
            c_cdr_wait: o = 6'b100_100;
            c_ready:    o = 6'b100_010;
            c_fault:    o = 6'b000_001;
            default:    o = 6'b000_000;
        endcase
        return {st, o, rc, fc};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {seq_state, phy_en, pll_rst, cdr_rst, seq_busy, seq_ready, seq_fault,
                retry_cnt, fault_code};
    endfunction

    task automatic expect_st(input logic [2:0] st, input logic [3:0] rc, input logic [1:0] fc);
        sb_q.push_back(exp_vec(st, rc, fc));
    endtask

    task automatic wait_state(input logic [2:0] st, input int max_cyc, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk_ref_24m);
            n++;
        end while (seq_state !== st && n < max_cyc);
        if (seq_state !== st) check(tag, 32'(seq_state), 32'(st));
    endtask

    // Scoreboard consumer: every state change must match the queue head
    always @(negedge clk_ref_24m) begin
        if (mon_en && seq_state !== prev_state) begin
            if (sb_q.size() == 0) check("sb_underflow", 32'(sb_q.size()), 32'd1);
            else                  check("sb_trans", 32'(obs_vec()), 32'(sb_q.pop_front()));
        end
        prev_state <= seq_state;
    end

    initial begin
        #(40 * 30000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk_ref_24m);
        check("reset_outputs", 32'(obs_vec()), 32'(exp_vec(c_idle, 4'd0, 2'd0)));
        rst_n = 1'b1;
        @(negedge clk_ref_24m);
        mon_en = 1'b1;

        // Nominal bring-up
        expect_st(c_pll_rst,  4'd0, 2'd0);
        expect_st(c_pll_wait, 4'd0, 2'd0);
        expect_st(c_cdr_rst,  4'd0, 2'd0);
        expect_st(c_cdr_wait, 4'd0, 2'd0);
        expect_st(c_ready,    4'd0, 2'd0);
        seq_en = 1'b1;
        wait_state(c_pll_rst, 5, "to_pll_rst");
        t0 = cyc;
        wait_state(c_pll_wait, 10, "to_pll_wait");
        check("pll_rst_width", 32'(cyc - t0), 32'd4);
        repeat (239) @(negedge clk_ref_24m);
        pll_lock = 1'b1;
        wait_state(c_cdr_rst, 5, "to_cdr_rst");
        wait_state(c_cdr_wait, 10, "to_cdr_wait");
        cdr_lock = 1'b1;
        repeat (1196) @(negedge clk_ref_24m);
        phy_ready = 1'b1;
        wait_state(c_ready, 5, "to_ready");
        check("up_seq_ready", 32'(seq_ready), 32'd1);
        check("up_retry_cnt", 32'(retry_cnt), 32'd0);
        check("up_fault_code", 32'(fault_code), 32'd0);

        // One-cycle cdr_lock glitches in READY: CDR-only recovery, retries accumulate
        for (int r = 1; r <= 3; r++) begin
            expect_st(c_cdr_rst,  4'(r), 2'd0);
            expect_st(c_cdr_wait, 4'(r), 2'd0);
            expect_st(c_ready,    4'(r), 2'd0);
            @(negedge clk_ref_24m);
            cdr_lock = 1'b0;
            @(negedge clk_ref_24m);
            cdr_lock = 1'b1;
            check("glitch_state", 32'(seq_state), 32'(c_cdr_rst));
            check("glitch_retry", 32'(retry_cnt), 32'(r));
            wait_state(c_ready, 20, "glitch_recover");
        end

        // Lock lost with no retries left
        expect_st(c_fault, 4'd3, 2'd3);
        @(negedge clk_ref_24m);
        pll_lock = 1'b0;
        @(negedge clk_ref_24m);
        check("lost_fault_code", 32'(fault_code), 32'd3);
        check("lost_phy_en", 32'(phy_en), 32'd0);
        expect_st(c_idle, 4'd0, 2'd0);
        seq_en    = 1'b0;
        cdr_lock  = 1'b0;
        phy_ready = 1'b0;
        @(negedge clk_ref_24m);
        check("clear_after_lost", 32'({seq_state, retry_cnt, fault_code}), 32'd0);

        // PLL lock arriving on the last allowed PLL_WAIT cycle
        expect_st(c_pll_rst,  4'd0, 2'd0);
        expect_st(c_pll_wait, 4'd0, 2'd0);
        expect_st(c_cdr_rst,  4'd0, 2'd0);
        seq_en = 1'b1;
        wait_state(c_pll_wait, 10, "late_to_pll_wait");
        t0 = cyc;
        repeat (511) @(negedge clk_ref_24m);
        pll_lock = 1'b1;
        wait_state(c_cdr_rst, 5, "late_to_cdr_rst");
        check("late_lock_time", 32'(cyc - t0), 32'd512);
        check("late_retry_cnt", 32'(retry_cnt), 32'd0);
        expect_st(c_idle, 4'd0, 2'd0);
        seq_en   = 1'b0;
        pll_lock = 1'b0;
        wait_state(c_idle, 5, "late_to_idle");

        // PLL never locks: three retries then FAULT
        for (int r = 0; r <= 3; r++) begin
            expect_st(c_pll_rst,  4'(r), 2'd0);
            expect_st(c_pll_wait, 4'(r), 2'd0);
        end
        expect_st(c_fault, 4'd3, 2'd1);
        seq_en = 1'b1;
        wait_state(c_pll_rst, 5, "to_pll_rst_2");
        t0 = cyc;
        wait_state(c_fault, 3000, "to_fault_pll");
        check("pll_fault_time", 32'(cyc - t0), 32'd2064);
        check("pll_fault_code", 32'(fault_code), 32'd1);
        check("pll_fault_retry", 32'(retry_cnt), 32'd3);
        check("pll_fault_phy_en", 32'(phy_en), 32'd0);
        repeat (20) @(negedge clk_ref_24m);
        check("fault_sticky", 32'(seq_state), 32'(c_fault));
        expect_st(c_idle, 4'd0, 2'd0);
        seq_en = 1'b0;
        @(negedge clk_ref_24m);
        check("clear_after_pll", 32'({seq_state, retry_cnt, fault_code}), 32'd0);

        // Asynchronous reset in the middle of CDR_WAIT
        expect_st(c_pll_rst,  4'd0, 2'd0);
        expect_st(c_pll_wait, 4'd0, 2'd0);
        expect_st(c_cdr_rst,  4'd0, 2'd0);
        expect_st(c_cdr_wait, 4'd0, 2'd0);
        pll_lock = 1'b1;
        cdr_lock = 1'b1;
        seq_en   = 1'b1;
        wait_state(c_cdr_wait, 30, "rst_to_cdr_wait");
        repeat (50) @(negedge clk_ref_24m);
        expect_st(c_idle, 4'd0, 2'd0);
        #5 rst_n = 1'b0;
        #1 check("async_reset", 32'(obs_vec()), 32'(exp_vec(c_idle, 4'd0, 2'd0)));
        repeat (3) @(negedge clk_ref_24m);
        expect_st(c_pll_rst, 4'd0, 2'd0);
        rst_n = 1'b1;
        @(negedge clk_ref_24m);
        check("post_reset_state", 32'(seq_state), 32'(c_pll_rst));
        expect_st(c_idle, 4'd0, 2'd0);
        seq_en   = 1'b0;
        pll_lock = 1'b0;
        cdr_lock = 1'b0;
        wait_state(c_idle, 5, "final_idle");
        repeat (2) @(negedge clk_ref_24m);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
